flash_cmd_sequencer: RTL and testbench
======================================

// Module: flash_cmd_sequencer
// PURPOSE
// Tracks the JEDEC command sequences that the CPU writes to PRG flash while PRG writes are enabled.
// Times program and erase operations with internal counters.
// While the flash is busy, it asks the top level to drive a synthesized status byte onto cpu_data
// in place of flash reads, so flashing code polls a stable source.
// It sits between the CPU bus decode (flash_we path) and the cpu_data output mux of the multicart top level.
// PARAMETERS
// UNLOCK_A      12'hAAA   first unlock address (x8 mode), compared against addr[11:0]
// UNLOCK_B      12'h555   second unlock address (x8 mode)
// PROG_CYCLES   16        m2 cycles that busy stays high after a byte program
// ERASE_CYCLES  100000    m2 cycles that busy stays high after a sector or chip erase
// CNT_W         17        busy counter width; must hold ERASE_CYCLES-1
// PORTS
// m2           in   1   clock: CPU M2; all state updates on its rising edge
// rst_n        in   1   asynchronous active-low reset
// enable       in   1   prg_write_enabled; when low, forces IDLE and aborts any operation
// wr_stb       in   1   1-cycle pulse: CPU write to flash space; addr and wr_data valid with it
// rd_stb       in   1   1-cycle pulse: CPU read from flash space
// addr         in   12  CPU address bits 11:0 of the access
// wr_data      in   8   CPU write data
// busy         out  1   program or erase in progress
// status_en    out  1   top level must drive status_data instead of flash data (equals busy)
// status_data  out  8   toggle-bit / data-polling status byte
// autoselect   out  1   flash is in autoselect (ID) mode
// op_done      out  1   1-cycle pulse when a program or erase completes normally
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, counter=0, toggle=0, prog_d7=0.
//   All outputs 0; status_data=8'h00.
// - Decoding happens only on wr_stb. The next state and outputs are registered, so they are visible
//   the clock after the strobe (1-cycle latency).
// - F0 written at any address in a non-busy state -> IDLE. This also exits AUTOSEL.
// - State transitions:
//   - IDLE: AA@UNLOCK_A -> UNL1
//   - UNL1: 55@UNLOCK_B -> UNL2
//   - UNL2: A0@UNLOCK_A -> PARM; 80@UNLOCK_A -> ER0; 90@UNLOCK_A -> AUTOSEL
//   - ER0: AA@UNLOCK_A -> ER1
//   - ER1: 55@UNLOCK_B -> ER2
//   - ER2: 30@any -> BUSY_E, sector erase; 10@UNLOCK_A -> BUSY_E, chip erase
//   - PARM: any write -> BUSY_P; latch prog_d7 = wr_data[7]
//   - Any other write in UNL1/UNL2/ER0/ER1/ER2 -> IDLE. It is not re-evaluated as a new AA in the same cycle.
//   - AUTOSEL: ignores everything except F0.
// - Entering BUSY_P loads counter=PROG_CYCLES-1; entering BUSY_E loads counter=ERASE_CYCLES-1.
//   The counter decrements every m2 clock.
//   At counter==0 in a busy state: state -> IDLE and op_done=1 for exactly one clock.
//   busy is therefore high for exactly PROG_CYCLES (or ERASE_CYCLES) clocks.
// - In BUSY_P/BUSY_E all wr_stb are ignored, including F0.
// - status_data while busy:
//   - bit7 = ~prog_d7 in BUSY_P, 0 in BUSY_E
//   - bit6 = toggle
//   - bit3 = 1 in BUSY_E, 0 in BUSY_P
//   - other bits 0
// - The toggle bit flips on each rd_stb while busy. It is cleared to 0 whenever the state is not busy.
// - If wr_stb and rd_stb are high in the same cycle, wr_stb is processed and the toggle does not flip.
// - enable=0 on any clock: next state IDLE and counter cleared. busy drops the next clock with no op_done.
//   Writes seen while enable=0 are ignored.
// - Counter arithmetic is unsigned, CNT_W bits, never decremented below 0.
//   A parameter value of 0 is illegal; an elaboration check flags it.
// - status_en = busy; autoselect = (state==AUTOSEL); all outputs are registered or decoded from registered state.
// TESTING
// - Program sequence AA@AAA, 55@555, A0@AAA, 8'h5A@123:
//   busy=1 the clock after the 4th strobe, for 16 clocks.
//   status_data=8'h80 until a read, then 8'hC0 after 1 rd_stb.
//   op_done pulses once; busy=0 afterwards.
// - Sector erase AA,55,80,AA,55,30@7FF:
//   busy=1 for 100000 clocks with status bit3=1.
//   3 reads give toggle 1,0,1.
//   F0 written mid-busy is ignored.
// - Sequence broken: AA@AAA then 12@555 -> state IDLE.
//   A following valid sequence AA,55,A0 still arms programming.
// - Autoselect: AA,55,90@AAA -> autoselect=1.
//   A0@AAA does not change it; F0@000 -> autoselect=0 the next clock.
// - Abort: enable driven low 5 clocks into BUSY_P -> busy=0 the next clock, op_done never pulses.
//   Separately, rst_n asserted low mid-erase clears all outputs asynchronously.
// - Same-cycle wr_stb and rd_stb while busy -> toggle unchanged.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command tracker for PRG flash: decodes unlock sequences and times program/erase, 1-cycle registered latency.
// While busy it supplies a toggle/data-polling status byte in place of flash reads; no backpressure, writes during busy are dropped.
module flash_cmd_sequencer #(
    parameter logic [11:0] UNLOCK_A     = 12'hAAA,
    parameter logic [11:0] UNLOCK_B     = 12'h555,
    parameter int          PROG_CYCLES  = 16,
    parameter int          ERASE_CYCLES = 100000,
    parameter int          CNT_W        = 17
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_stb,
    input  logic        rd_stb,
    input  logic [11:0] addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        status_en,
    output logic [7:0]  status_data,
    output logic        autoselect,
    output logic        op_done
);

    generate
        if (PROG_CYCLES < 1 || ERASE_CYCLES < 1 ||
            longint'(PROG_CYCLES - 1) >= (longint'(1) << CNT_W) ||
            longint'(ERASE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_param
            $error("flash_cmd_sequencer: cycle counts must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_UNL1, S_UNL2, S_PARM, S_ER0, S_ER1, S_ER2, S_AUTOSEL, S_BUSY_P, S_BUSY_E
    } state_t;

    localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             toggle, toggle_d;
    logic             prog_d7, prog_d7_d;
    logic             op_done_d;
    logic             is_a, is_b, in_busy, next_busy;

    assign is_a    = (addr == UNLOCK_A);
    assign is_b    = (addr == UNLOCK_B);
    assign in_busy = (state == S_BUSY_P) || (state == S_BUSY_E);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        prog_d7_d = prog_d7;
        op_done_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (in_busy) begin
            if (cnt == '0) begin
                state_d   = S_IDLE;
                op_done_d = 1'b1;
            end else begin
                cnt_d = cnt - 1'b1;
            end
        end else if (wr_stb) begin
            // Reset command wins over every non-busy state, including PARM.
            if (wr_data == 8'hF0) begin
                state_d = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:    if (wr_data == 8'hAA && is_a) state_d = S_UNL1;
                    S_UNL1:    state_d = (wr_data == 8'h55 && is_b) ? S_UNL2 : S_IDLE;
                    S_UNL2: begin
                        if      (wr_data == 8'hA0 && is_a) state_d = S_PARM;
                        else if (wr_data == 8'h80 && is_a) state_d = S_ER0;
                        else if (wr_data == 8'h90 && is_a) state_d = S_AUTOSEL;
                        else                               state_d = S_IDLE;
                    end
                    S_ER0:     state_d = (wr_data == 8'hAA && is_a) ? S_ER1 : S_IDLE;
                    S_ER1:     state_d = (wr_data == 8'h55 && is_b) ? S_ER2 : S_IDLE;
                    S_ER2: begin
                        if (wr_data == 8'h30 || (wr_data == 8'h10 && is_a)) begin
                            state_d = S_BUSY_E;
                            cnt_d   = ERASE_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_PARM: begin
                        state_d   = S_BUSY_P;
                        cnt_d     = PROG_LOAD;
                        prog_d7_d = wr_data[7];
                    end
                    S_AUTOSEL: state_d = S_AUTOSEL;
                    default:   state_d = S_IDLE;
                endcase
            end
        end
    end

    assign next_busy = (state_d == S_BUSY_P) || (state_d == S_BUSY_E);

    always_comb begin
        toggle_d = 1'b0;
        if (next_busy)
            toggle_d = (in_busy && rd_stb && !wr_stb) ? ~toggle : toggle;
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            toggle  <= 1'b0;
            prog_d7 <= 1'b0;
            op_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            toggle  <= toggle_d;
            prog_d7 <= prog_d7_d;
            op_done <= op_done_d;
        end
    end

    assign busy        = in_busy;
    assign status_en   = in_busy;
    assign autoselect  = (state == S_AUTOSEL);
    assign status_data = in_busy ? {(state == S_BUSY_P) & ~prog_d7, toggle, 2'b00,
                                    (state == S_BUSY_E), 3'b000} : 8'h00;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized scoreboard bench: a command-history reference model predicts outputs, a negedge monitor compares.
module tb_flash_cmd_sequencer;

    localparam int PROG_N  = 16;
    localparam int ERASE_N = 200;

    logic        m2 = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_stb = 1'b0;
    logic        rd_stb = 1'b0;
    logic [11:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic        busy, status_en, autoselect, op_done;
    logic [7:0]  status_data;

    always #5 m2 = ~m2;

    flash_cmd_sequencer #(
        .UNLOCK_A(12'hAAA), .UNLOCK_B(12'h555),
        .PROG_CYCLES(PROG_N), .ERASE_CYCLES(ERASE_N), .CNT_W(17)
    ) dut (
        .m2(m2), .rst_n(rst_n), .enable(enable), .wr_stb(wr_stb), .rd_stb(rd_stb),
        .addr(addr), .wr_data(wr_data), .busy(busy), .status_en(status_en),
        .status_data(status_data), .autoselect(autoselect), .op_done(op_done)
    );

    typedef struct packed {
        logic       busy;
        logic [7:0] status;
        logic       autosel;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: history of writes matched against the command tables.
    logic [19:0] hist[$];
    logic [8:0]  pd[4][6];   // bit8: data don't-care
    logic [12:0] pa[4][6];   // bit12: address don't-care
    int          plen[4];
    int          busy_rem;
    bit          kind_e, m_d7, m_tog, m_auto, m_done;

    task automatic set_pat(input int p, input int i, input logic [8:0] d, input logic [12:0] a);
        pd[p][i] = d;
        pa[p][i] = a;
    endtask

    task automatic init_patterns();
        for (int p = 0; p < 4; p++) begin
            set_pat(p, 0, 9'h0AA, 13'h0AAA);
            set_pat(p, 1, 9'h055, 13'h0555);
            set_pat(p, 4, 9'h055, 13'h0555);
            set_pat(p, 5, 9'h000, 13'h0000);
        end
        set_pat(0, 2, 9'h0A0, 13'h0AAA); set_pat(0, 3, 9'h100, 13'h1000); plen[0] = 4;
        set_pat(1, 2, 9'h080, 13'h0AAA); set_pat(1, 3, 9'h0AA, 13'h0AAA);
        set_pat(1, 5, 9'h030, 13'h1000); plen[1] = 6;
        set_pat(2, 2, 9'h080, 13'h0AAA); set_pat(2, 3, 9'h0AA, 13'h0AAA);
        set_pat(2, 5, 9'h010, 13'h0AAA); plen[2] = 6;
        set_pat(3, 2, 9'h090, 13'h0AAA); set_pat(3, 3, 9'h000, 13'h0000); plen[3] = 3;
    endtask

    // -1 broken, 0 incomplete prefix, 1 program, 2 erase, 3 autoselect
    function automatic int classify();
        int res = -1;
        for (int p = 0; p < 4; p++) begin
            bit ok = (hist.size() <= plen[p]);
            for (int i = 0; i < hist.size() && ok; i++) begin
                if (!pd[p][i][8] && pd[p][i][7:0] != hist[i][19:12]) ok = 0;
                if (!pa[p][i][12] && pa[p][i][11:0] != hist[i][11:0]) ok = 0;
            end
            if (ok) begin
                if (hist.size() == plen[p]) res = (p == 0) ? 1 : (p == 3) ? 3 : 2;
                else if (res < 0) res = 0;
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        hist.delete();
        busy_rem = 0; kind_e = 0; m_d7 = 0; m_tog = 0; m_auto = 0; m_done = 0;
    endtask

    task automatic model_step(input bit en, input bit wr, input bit rd,
                              input logic [11:0] a, input logic [7:0] d);
        m_done = 0;
        if (!en) begin
            busy_rem = 0; hist.delete(); m_auto = 0; m_tog = 0;
        end else if (busy_rem > 0) begin
            busy_rem--;
            if (busy_rem == 0) begin
                m_done = 1; m_tog = 0;
            end else if (rd && !wr) begin
                m_tog = ~m_tog;
            end
        end else begin
            m_tog = 0;
            if (wr) begin
                if (d == 8'hF0) begin
                    hist.delete(); m_auto = 0;
                end else if (!m_auto) begin
                    int c;
                    hist.push_back({d, a});
                    c = classify();
                    if (c != 0) hist.delete();
                    if (c == 1) begin busy_rem = PROG_N;  kind_e = 0; m_d7 = d[7]; end
                    if (c == 2) begin busy_rem = ERASE_N; kind_e = 1; end
                    if (c == 3) m_auto = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.busy    = (busy_rem > 0);
        e.status  = e.busy ? {kind_e ? 1'b0 : ~m_d7, m_tog, 2'b00, kind_e, 3'b000} : 8'h00;
        e.autosel = m_auto;
        e.done    = m_done;
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge m2);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({busy, status_en, status_data, autoselect, op_done} !==
                    {e.busy, e.busy, e.status, e.autosel, e.done}) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got busy=%b en=%b status=%h auto=%b done=%b, want busy=%b en=%b status=%h auto=%b done=%b",
                             $time, busy, status_en, status_data, autoselect, op_done,
                             e.busy, e.busy, e.status, e.autosel, e.done);
                end
            end
        end
    end

    task automatic cycle(input bit en, input bit wr, input bit rd,
                         input logic [11:0] a, input logic [7:0] d);
        @(negedge m2);
        #1;
        rst_n = 1'b1; enable = en; wr_stb = wr; rd_stb = rd; addr = a; wr_data = d;
        model_step(en, wr, rd, a, d);
        exp_q.push_back(model_out());
    endtask

    task automatic wr_cmd(input logic [11:0] a, input logic [7:0] d);
        cycle(1, 1, 0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 12'h000, 8'h00);
    endtask

    task automatic rd_cycle();
        cycle(1, 0, 1, 12'h000, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge m2);
        #1;
        rst_n = 1'b0; enable = 0; wr_stb = 0; rd_stb = 0;
        model_reset();
        exp_q.push_back(model_out());
        #2;
        vectors++;
        if ({busy, status_en, status_data, autoselect, op_done} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset t=%0t got busy=%b en=%b status=%h auto=%b done=%b, want all zero",
                     $time, busy, status_en, status_data, autoselect, op_done);
        end
    endtask

    task automatic unlock();
        wr_cmd(12'hAAA, 8'hAA);
        wr_cmd(12'h555, 8'h55);
    endtask

    function automatic logic [7:0] pick_d();
        case ($urandom_range(0, 8))
            0: return 8'hAA;  1: return 8'h55;  2: return 8'hA0;
            3: return 8'h80;  4: return 8'h90;  5: return 8'h30;
            6: return 8'h10;  7: return 8'hF0;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [11:0] pick_a();
        case ($urandom_range(0, 2))
            0: return 12'hAAA;
            1: return 12'h555;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic rnd_cycle();
        cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, pick_a(), pick_d());
    endtask

    initial begin : stim
        init_patterns();
        model_reset();
        do_reset();

        // byte program, one read during busy
        unlock(); wr_cmd(12'hAAA, 8'hA0); wr_cmd(12'h123, 8'h5A);
        idle(3); rd_cycle(); idle(16);

        // sector erase with reads and an ignored F0
        unlock(); wr_cmd(12'hAAA, 8'h80); unlock(); wr_cmd(12'h7FF, 8'h30);
        idle(5); rd_cycle(); idle(2); rd_cycle(); idle(2); rd_cycle();
        wr_cmd(12'h000, 8'hF0); idle(ERASE_N);

        // broken sequence, then a valid program
        wr_cmd(12'hAAA, 8'hAA); wr_cmd(12'h555, 8'h12); idle(2);
        unlock(); wr_cmd(12'hAAA, 8'hA0); wr_cmd(12'h000, 8'hC3); idle(PROG_N + 2);

        // autoselect entry and exit
        unlock(); wr_cmd(12'hAAA, 8'h90); idle(2);
        wr_cmd(12'hAAA, 8'hA0); idle(2); wr_cmd(12'h000, 8'hF0); idle(2);

        // abort by enable low five clocks into programming
        unlock(); wr_cmd(12'hAAA, 8'hA0); wr_cmd(12'h001, 8'h11);
        idle(4); cycle(0, 0, 0, 12'h000, 8'h00); idle(PROG_N + 2);

        // chip erase, simultaneous write+read keeps toggle
        unlock(); wr_cmd(12'hAAA, 8'h80); unlock(); wr_cmd(12'hAAA, 8'h10);
        idle(2); cycle(1, 1, 1, 12'hAAA, 8'hAA); idle(2); rd_cycle();
        cycle(1, 1, 1, 12'h000, 8'hF0); idle(30);

        // reset asserted mid-erase
        do_reset();

        // randomized command bursts with occasional corruption
        for (int it = 0; it < 150; it++) begin
            int kind = $urandom_range(0, 3);
            logic [7:0]  sd[6];
            logic [11:0] sa[6];
            int n;
            sd[0] = 8'hAA; sa[0] = 12'hAAA; sd[1] = 8'h55; sa[1] = 12'h555;
            sd[3] = 8'hAA; sa[3] = 12'hAAA; sd[4] = 8'h55; sa[4] = 12'h555;
            sa[2] = 12'hAAA;
            sd[2] = (kind == 0) ? 8'hA0 : (kind == 3) ? 8'h90 : 8'h80;
            sd[5] = (kind == 1) ? 8'h30 : 8'h10;
            sa[5] = (kind == 1) ? 12'($urandom) : 12'hAAA;
            n = (kind == 0) ? 4 : (kind == 3) ? 3 : 6;
            if (kind == 0) begin sd[3] = 8'($urandom); sa[3] = 12'($urandom); end
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 11) == 0) sd[i] = pick_d();
                if ($urandom_range(0, 11) == 0) sa[i] = pick_a();
                cycle($urandom_range(0, 149) != 0, 1, $urandom_range(0, 1) == 1, sa[i], sd[i]);
                if ($urandom_range(0, 3) == 0) rnd_cycle();
            end
            for (int i = 0; i < $urandom_range(0, 40); i++) rnd_cycle();
            if (kind != 0 && $urandom_range(0, 1) == 1) idle(ERASE_N / 2);
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        idle(ERASE_N + 2);
        repeat (3) @(negedge m2);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
